// File: rtl/multi_digit_counter_display.sv
// N-channel debounced button counter with time-multiplexed common-anode 7-segment driver.
// Each channel: 2-flop synchroniser -> symmetric debouncer -> rising-edge detect -> mod-MODULUS digit.
module multi_digit_counter_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int MODULUS       = 10,
    parameter int DEBOUNCE_BITS = 16,
    parameter int REFRESH_DIV   = 4,
    parameter int CASCADE       = 0
) (
    input  logic                    sysclock,
    input  logic                    reset_n,
    input  logic [NUM_DIGITS-1:0]   raw,
    input  logic [NUM_DIGITS-1:0]   clr,
    input  logic                    down,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    carry_out
);

    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [4:0] MOD5 = 5'(MODULUS);

    logic [NUM_DIGITS-1:0]    sync1, sync2, clean, clean_d, press, cout;
    logic [DEBOUNCE_BITS-1:0] db_cnt [NUM_DIGITS];
    logic [3:0]               dig [NUM_DIGITS];
    logic [3:0]               dig_nxt [NUM_DIGITS];
    logic [PW-1:0]            presc;
    logic [IW-1:0]            idx;

    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            clean   <= '0;
            clean_d <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            clean_d <= clean;
            // Input must hold a new level for DB_MAX+1 consecutive cycles to be accepted.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sync2[i] == clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    clean[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = clean & ~clean_d;

    // Carry/borrow ripples through all digits combinationally so a chain settles on one edge.
    always_comb begin
        logic       ripple;
        logic [4:0] v;
        logic [4:0] amt;
        ripple = 1'b0;
        cout   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v   = {1'b0, dig[i]};
            amt = {4'b0, press[i]} + {4'b0, ripple};
            dig_nxt[i] = dig[i];
            if (clr[i]) begin
                dig_nxt[i] = 4'h0;
            end else if (!down) begin
                if (v + amt >= MOD5) begin
                    dig_nxt[i] = 4'(v + amt - MOD5);
                    cout[i]    = 1'b1;
                end else begin
                    dig_nxt[i] = 4'(v + amt);
                end
            end else begin
                if (v < amt) begin
                    dig_nxt[i] = 4'(v + MOD5 - amt);
                    cout[i]    = 1'b1;
                end else begin
                    dig_nxt[i] = 4'(v - amt);
                end
            end
            ripple = (CASCADE != 0) ? cout[i] : 1'b0;
        end
    end

    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= 4'h0;
            carry_out <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) dig[i] <= dig_nxt[i];
            carry_out <= cout[NUM_DIGITS-1];
        end
    end

    always_comb begin
        digits = '0;
        for (int i = 0; i < NUM_DIGITS; i++) digits[4*i +: 4] = dig[i];
    end

    always_ff @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: seg_decode = 8'hC0;
            4'h1: seg_decode = 8'hF9;
            4'h2: seg_decode = 8'hA4;
            4'h3: seg_decode = 8'hB0;
            4'h4: seg_decode = 8'h99;
            4'h5: seg_decode = 8'h92;
            4'h6: seg_decode = 8'h82;
            4'h7: seg_decode = 8'hF8;
            4'h8: seg_decode = 8'h80;
            4'h9: seg_decode = 8'h90;
            4'hA: seg_decode = 8'h88;
            4'hB: seg_decode = 8'h83;
            4'hC: seg_decode = 8'hC6;
            4'hD: seg_decode = 8'hA1;
            4'hE: seg_decode = 8'h86;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    assign anode = ~(NUM_DIGITS'(1) << idx);
    assign seg   = seg_decode(dig[idx]);

endmodule

// File: tb/tb_multi_digit_counter_display.sv
// Bench for multi_digit_counter_display: two instances (CASCADE=0 and 1) share one stimulus
// stream; digit changes are checked against an expected queue per instance.
module tb_multi_digit_counter_display;

    logic        sysclock;
    logic        reset_n;
    logic [3:0]  raw;
    logic [3:0]  clr;
    logic        down;
    logic [3:0]  anode_c0, anode_c1;
    logic [7:0]  seg_c0, seg_c1;
    logic [15:0] digits_c0, digits_c1;
    logic        carry_c0, carry_c1;

    int checks = 0;
    int failures = 0;
    int carry_cnt_c0 = 0;
    int carry_cnt_c1 = 0;
    int cyc;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_c0 = 16'h0;
    logic [15:0] exp_c1 = 16'h0;
    logic [15:0] last_c0 = 16'h0;
    logic [15:0] last_c1 = 16'h0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    multi_digit_counter_display #(
        .NUM_DIGITS(4), .MODULUS(10), .DEBOUNCE_BITS(2), .REFRESH_DIV(4), .CASCADE(0)
    ) u_c0 (
        .sysclock(sysclock), .reset_n(reset_n), .raw(raw), .clr(clr), .down(down),
        .anode(anode_c0), .seg(seg_c0), .digits(digits_c0), .carry_out(carry_c0)
    );

    multi_digit_counter_display #(
        .NUM_DIGITS(4), .MODULUS(10), .DEBOUNCE_BITS(2), .REFRESH_DIV(4), .CASCADE(1)
    ) u_c1 (
        .sysclock(sysclock), .reset_n(reset_n), .raw(raw), .clr(clr), .down(down),
        .anode(anode_c1), .seg(seg_c1), .digits(digits_c1), .carry_out(carry_c1)
    );

    // clock / reset-relative cycle counter
    initial begin
        sysclock = 1'b0;
        forever #5 sysclock = ~sysclock;
    end

    always @(posedge sysclock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // scoreboard monitors: every change on digits pops one expected value
    always @(negedge sysclock) begin
        if (digits_c0 !== last_c0) begin
            if (exp_q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL c0_unexpected_change: got %0h expected no change", digits_c0);
            end else begin
                chk("c0_digits", {16'h0, digits_c0}, {16'h0, exp_q0.pop_front()});
            end
            last_c0 = digits_c0;
        end
        if (digits_c1 !== last_c1) begin
            if (exp_q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL c1_unexpected_change: got %0h expected no change", digits_c1);
            end else begin
                chk("c1_digits", {16'h0, digits_c1}, {16'h0, exp_q1.pop_front()});
            end
            last_c1 = digits_c1;
        end
        if (carry_c0 === 1'b1) carry_cnt_c0++;
        if (carry_c1 === 1'b1) carry_cnt_c1++;
    end

    // driver tasks
    task automatic tick();
        @(posedge sysclock);
        #1;
    endtask

    task automatic expect_state(input logic [15:0] e0, input logic [15:0] e1);
        if (e0 != exp_c0) exp_q0.push_back(e0);
        if (e1 != exp_c1) exp_q1.push_back(e1);
        exp_c0 = e0;
        exp_c1 = e1;
    endtask

    // raw rises before edge 1; the press lands on edge 7; clr is applied on that edge
    task automatic press(input logic [3:0] mask, input logic [3:0] cmask,
                         input logic [15:0] e0, input logic [15:0] e1);
        raw = mask;
        repeat (6) tick();
        expect_state(e0, e1);
        clr = cmask;
        tick();
        clr = 4'h0;
        repeat (2) tick();
        raw = 4'h0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        expect_state(16'h0, 16'h0);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        logic [3:0] d;
        logic [1:0] ei;
        raw = 4'h0;
        clr = 4'h0;
        down = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        chk("reset_digits_c1", {16'h0, digits_c1}, 32'h0);
        chk("reset_digits_c0", {16'h0, digits_c0}, 32'h0);
        chk("reset_anode", {28'h0, anode_c1}, 32'hE);
        chk("reset_seg", {24'h0, seg_c1}, 32'hC0);
        chk("reset_carry", {31'h0, carry_c1}, 32'h0);
        reset_n = 1'b1;

        // preload 4321 then check the scan sequence against the reset-relative cycle count
        press(4'b1111, 4'h0, 16'h1111, 16'h1111);
        press(4'b1110, 4'h0, 16'h2221, 16'h2221);
        press(4'b1100, 4'h0, 16'h3321, 16'h3321);
        press(4'b1000, 4'h0, 16'h4321, 16'h4321);
        for (int k = 0; k < 20; k++) begin
            ei = 2'((cyc / 4) % 4);
            d  = exp_c1[4*ei +: 4];
            chk("scan_anode", {28'h0, anode_c1}, {28'h0, ~(4'b0001 << ei)});
            chk("scan_seg", {24'h0, seg_c1}, {24'h0, seg_tab[d]});
            tick();
        end

        // async reset mid-debounce and between edges
        raw = 4'b0001;
        repeat (3) tick();
        expect_state(16'h0, 16'h0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_digits_c1", {16'h0, digits_c1}, 32'h0);
        chk("async_reset_digits_c0", {16'h0, digits_c0}, 32'h0);
        chk("async_reset_anode", {28'h0, anode_c1}, 32'hE);
        chk("async_reset_seg", {24'h0, seg_c1}, 32'hC0);
        chk("async_reset_carry", {31'h0, carry_c1}, 32'h0);
        raw = 4'h0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (15) tick();
        chk("no_count_after_reset", {16'h0, digits_c1}, 32'h0);

        // bounce on raw[0], then a clean hold: one increment, 7 edges after the final rise
        for (int k = 0; k < 10; k++) begin
            raw[0] = (k % 2 == 0);
            repeat (2) tick();
        end
        raw[0] = 1'b1;
        repeat (6) tick();
        chk("bounce_before_land", {16'h0, digits_c1}, 32'h0);
        expect_state(16'h0001, 16'h0001);
        tick();
        chk("bounce_land_edge7", {16'h0, digits_c1}, 32'h0001);
        repeat (3) tick();
        raw[0] = 1'b0;
        repeat (12) tick();
        chk("release_no_count", {16'h0, digits_c1}, 32'h0001);

        // wrap of digit1: isolated without cascade, carries into digit2 with cascade
        for (int k = 1; k <= 10; k++) begin
            press(4'b0010, 4'h0, {8'h00, 4'(k % 10), 4'h1},
                  (k == 10) ? 16'h0101 : {8'h00, 4'(k % 10), 4'h1});
        end
        chk("wrap_carry_c0", 32'(carry_cnt_c0), 32'd0);
        chk("wrap_carry_c1", 32'(carry_cnt_c1), 32'd0);

        do_reset();
        for (int k = 1; k <= 9; k++) press(4'b0011, 4'h0, {8'h00, 4'(k), 4'(k)}, {8'h00, 4'(k), 4'(k)});
        press(4'b0001, 4'h0, 16'h0090, 16'h0100);

        // down counting with borrow
        do_reset();
        press(4'b0010, 4'h0, 16'h0010, 16'h0010);
        down = 1'b1;
        press(4'b0001, 4'h0, 16'h0019, 16'h0009);
        do_reset();
        press(4'b0001, 4'h0, 16'h0009, 16'h9999);
        chk("down_wrap_carry_c0", 32'(carry_cnt_c0), 32'd0);
        chk("down_wrap_carry_c1", 32'(carry_cnt_c1), 32'd1);
        press(4'b1000, 4'h0, 16'h9009, 16'h8999);
        chk("top_wrap_carry_c0", 32'(carry_cnt_c0), 32'd1);
        chk("top_wrap_carry_c1", 32'(carry_cnt_c1), 32'd1);
        down = 1'b0;

        // clear priority over incoming carry and over a press
        do_reset();
        for (int k = 1; k <= 9; k++) press(4'b0011, 4'h0, {8'h00, 4'(k), 4'(k)}, {8'h00, 4'(k), 4'(k)});
        press(4'b0001, 4'b0010, 16'h0000, 16'h0000);
        press(4'b0001, 4'h0, 16'h0001, 16'h0001);
        press(4'b0001, 4'b0001, 16'h0000, 16'h0000);
        chk("final_carry_c1", 32'(carry_cnt_c1), 32'd1);

        repeat (4) tick();
        chk("q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("q1_drained", 32'(exp_q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_digit_counter_display.md
Name: multi_digit_counter_display

Overview:
N-channel button counter with a time-multiplexed 7-segment driver; successor to the fixed 4-button mod-10 display. Each raw button goes through a 2-flop synchroniser, a symmetric debouncer and a rising-edge detector. The edge drives a per-digit mod-MODULUS up/down counter; counters optionally cascade into one multi-digit number. Digits are scanned onto a common-anode display with active-low anodes and segments.

Parameters:
NUM_DIGITS, 4, channel/digit count (1..8)
MODULUS, 10, counter modulus per digit (2..16); values 10-15 display as hex A-F
DEBOUNCE_BITS, 16, debounce counter width; DB_MAX = 2**DEBOUNCE_BITS-1
REFRESH_DIV, 4, sysclock cycles each digit is lit (>=1)
CASCADE, 0, 1 = wrap of digit i carries/borrows into digit i+1

Ports:
sysclock  in  1  system clock, all state on posedge
reset_n  in  1  asynchronous, active-low reset
raw  in  NUM_DIGITS  raw button inputs, asynchronous, active-high
clr  in  NUM_DIGITS  synchronous per-digit clear, active-high
down  in  1  count direction: 0 = up, 1 = down (sampled each cycle)
anode  out  NUM_DIGITS  digit enables, active-low one-hot
seg  out  8  segments active-low; bit0=a .. bit6=g, bit7=dp (always 1)
digits  out  4*NUM_DIGITS  counter values; digit i at [4i+3:4i]
carry_out  out  1  one-cycle pulse when the top digit wraps (either direction)

Behaviour:
- Reset (async, reset_n=0): all sync flops, debounce counters, clean states, edge regs, digits, prescaler and scan index go to 0. Outputs immediately: digits=0, anode=~1 (e.g. 4'b1110), seg=8'hC0, carry_out=0.
- Synchroniser: 2 flops per channel, giving sync[i].
- Debounce, per channel:
  - If sync==clean: cnt<=0.
  - Else if cnt==DB_MAX: clean<=sync and cnt<=0.
  - Else: cnt<=cnt+1.
  - Applies to both edges.
- Press: press[i] = clean[i] & ~clean_d[i] (clean_d is registered). It is high for exactly one cycle per debounced press. Release causes no count.
- Latency: raw rises before edge 1 -> clean rises at edge DB_MAX+3 -> digit updates at edge DB_MAX+4.
- Digit update, each cycle, i = 0..NUM_DIGITS-1:
  - amt = press[i] + cin[i]. cin[0] = 0. cin[i] = cout[i-1] if CASCADE, else 0.
  - Up: if v+amt >= MODULUS then v <= v+amt-MODULUS, cout=1; else v <= v+amt.
  - Down: if v < amt then v <= v-amt+MODULUS, cout=1; else v <= v-amt.
  - Carry ripples combinationally within the same cycle, so a whole chain updates on one edge.
- clr[i] has priority over press and incoming carry. The cleared digit goes to 0 and emits cout=0. Digits above it still take their own presses.
- carry_out is registered from cout[NUM_DIGITS-1] and asserts the cycle after the top-digit wrap edge. It is independent of CASCADE.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. On terminal count, idx advances with wrap NUM_DIGITS-1 -> 0.
  - anode = ~(1<<idx).
  - seg is a combinational decode of digit[idx], so a digit change shows in the same cycle it is registered.
- Encoding (active-low, dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- down changing mid-operation takes effect on the next update edge. No state is lost.
- reset_n asserted mid-debounce or mid-scan aborts the operation; no press is generated after release of reset.

Test Plan:
(All scenarios use NUM_DIGITS=4, MODULUS=10, DEBOUNCE_BITS=2, REFRESH_DIV=4.)
1. Reset: preload digits=4321 and drop reset_n between clock edges -> digits=0, anode=1110, seg=C0 with no clock edge needed; no count after reset_n rises with raw low.
2. Bounce: raw[0] toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one increment, digit0=1, landing 7 edges after the final rise; later release gives no change.
3. Wrap, CASCADE=0: 10 presses on raw[1] -> digit1 runs 0..9 then 0, digit2 stays 0, carry_out stays 0. Rerun with CASCADE=1 and digits=0099: one press on raw[0] -> 0100 on a single edge.
4. Down, CASCADE=1, digits=0010: down=1, one press on raw[0] -> 0009. Then digits=0000 plus a press -> 9999 and carry_out pulses for 1 cycle.
5. Priority, CASCADE=1, digits=0099: clr[1] asserted on the same edge as the raw[0] press pulse -> digits=0000 (digit0 wraps, digit1 cleared), digit2 stays 0; clr[0] alone with a press on digit0 -> digit0=0.
6. Scan: digits=4321 -> anode runs 1110, 1101, 1011, 0111, each held 4 cycles, with seg F9, A4, B0, 99 respectively, then wraps to 1110/F9.
